// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch FIFO and redirect; optional halt when FETCH_HALT_EN is defined
module fetch_unit #(
  parameter int w        = 8,
  parameter int op_w     = 3,
  parameter int pc_w     = 8,
  parameter int depth    = 2,
  parameter int reset_pc = 0,
  parameter int halt_op  = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [pc_w-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [4*w-1:0]    mem_rdata,
  input  logic              jump_valid,
  input  logic [pc_w-1:0]   jump_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [op_w-1:0]   out_op,
  output logic [w-1:0]      out_a1,
  output logic [w-1:0]      out_a2,
  output logic [w-1:0]      out_a3,
  output logic [pc_w-1:0]   out_pc,
  output logic              halted
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  localparam logic [cnt_w-1:0] c_depth    = cnt_w'(depth);
  localparam logic [cnt_w-1:0] c_cnt_one  = cnt_w'(1);
  localparam logic [ptr_w-1:0] c_ptr_one  = ptr_w'(1);
  localparam logic [pc_w-1:0]  c_reset_pc = pc_w'(reset_pc);
  localparam logic [pc_w-1:0]  c_pc_one   = pc_w'(1);
  localparam logic [op_w-1:0]  c_halt_op  = op_w'(halt_op);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  // Fetch FSM state and memory-side registers
  logic [1:0]       r_state;
  logic [pc_w-1:0]  r_pc;
  logic             r_mem_req;
  logic [pc_w-1:0]  r_mem_addr;

  // Prefetch FIFO bookkeeping and storage
  logic [ptr_w-1:0] r_wr_ptr;
  logic [ptr_w-1:0] r_rd_ptr;
  logic [cnt_w-1:0] r_count;
  logic [op_w-1:0]  r_fifo_op [depth];
  logic [w-1:0]     r_fifo_a1 [depth];
  logic [w-1:0]     r_fifo_a2 [depth];
  logic [w-1:0]     r_fifo_a3 [depth];
  logic [pc_w-1:0]  r_fifo_pc [depth];

  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  logic             w_room_after_push;
  logic             w_halt_hit;
  logic [pc_w-1:0]  w_pc_inc;
  logic             w_unused;

  // A jump overrides both sides of the FIFO: acked data is dropped and a pop is ignored
  assign w_not_empty       = (r_count != '0);
  assign w_push            = (r_state == S_REQ) && mem_ack && !jump_valid;
  assign w_pop             = w_not_empty && out_ready && !jump_valid;
  assign w_room_after_push = w_pop || (r_count < (c_depth - c_cnt_one));
  assign w_pc_inc          = r_pc + c_pc_one;

`ifdef FETCH_HALT_EN
  assign w_halt_hit = (mem_rdata[3*w +: op_w] == c_halt_op);
  assign halted     = (r_state == S_HALTED);
  assign w_unused   = ^mem_rdata[4*w-1:3*w];
`else
  assign w_halt_hit = 1'b0;
  assign halted     = 1'b0;
  assign w_unused   = ^{mem_rdata[4*w-1:3*w], c_halt_op};
`endif

  // FIFO pointers and occupancy; cleared in the cycle a jump arrives
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (jump_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the gated head outputs
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr] <= mem_rdata[3*w +: op_w];
      r_fifo_a1[r_wr_ptr] <= mem_rdata[2*w +: w];
      r_fifo_a2[r_wr_ptr] <= mem_rdata[w +: w];
      r_fifo_a3[r_wr_ptr] <= mem_rdata[0 +: w];
      r_fifo_pc[r_wr_ptr] <= r_pc;
    end
  end

  // Fetch FSM: one outstanding request, never withdrawn once raised
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= c_reset_pc;
      r_mem_req  <= 1'b0;
      r_mem_addr <= c_reset_pc;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (jump_valid) begin
            r_pc <= jump_addr;
          end else if (r_count < c_depth) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (jump_valid) begin
            r_pc <= jump_addr;
            if (mem_ack) begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem_ack) begin
            r_pc <= w_pc_inc;
            if (w_halt_hit) begin
              r_state   <= S_HALTED;
              r_mem_req <= 1'b0;
            end else if (w_room_after_push) begin
              r_mem_addr <= w_pc_inc;
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (jump_valid) r_pc <= jump_addr;
          if (mem_ack) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
`ifdef FETCH_HALT_EN
        S_HALTED: begin
          if (jump_valid) begin
            r_state <= S_IDLE;
            r_pc    <= jump_addr;
          end
        end
`endif
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_valid = w_not_empty;
  assign out_op    = w_not_empty ? r_fifo_op[r_rd_ptr] : '0;
  assign out_a1    = w_not_empty ? r_fifo_a1[r_rd_ptr] : '0;
  assign out_a2    = w_not_empty ? r_fifo_a2[r_rd_ptr] : '0;
  assign out_a3    = w_not_empty ? r_fifo_a3[r_rd_ptr] : '0;
  assign out_pc    = w_not_empty ? r_fifo_pc[r_rd_ptr] : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that feeds the decoder and router. It replaces the hand-driven i0..i3 instruction registers.
- Walks a program counter through instruction memory over a req/ack interface and buffers fetched words in a small prefetch FIFO.
- Presents one split instruction (op plus three byte arguments) per valid/ready handshake.
- Supports a redirect (jump) that flushes all in-flight and buffered instructions.

Parameters:
- w, 8, argument and data-bus width; an instruction word is 4*w bits.
- op_w, 3, opcode width; the opcode is the low op_w bits of the top w-bit field.
- pc_w, 8, program counter and memory address width.
- depth, 2, prefetch FIFO entries (power of two, >=2).
- reset_pc, 0, PC value loaded at reset.
- halt_op, 0, opcode that stops fetch (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_req  out  1  memory read request.
- mem_addr  out  pc_w  read address; held stable while mem_req=1.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  4*w  instruction word: [4w-1:3w] op field, [3w-1:2w] arg1, [2w-1:w] arg2, [w-1:0] arg3.
- jump_valid  in  1  redirect request, one-cycle pulse.
- jump_addr  in  pc_w  redirect target.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decoder accepts the head.
- out_op  out  op_w  opcode (decoder i0).
- out_a1, out_a2, out_a3  out  w each  arguments (router i1, i2, i3).
- out_pc  out  pc_w  address of the presented instruction.
- halted  out  1  fetch stopped on halt_op (always 0 without the feature).

Behaviour:
- Reset (asynchronous, active-low): pc=reset_pc, FIFO empty, out_valid=0, mem_req=0, halted=0, FSM=IDLE. All out_* data outputs read 0 while the FIFO is empty.
- FSM states: IDLE, REQ, DRAIN, plus HALTED with the optional feature.
  - IDLE -> REQ when FIFO count + 0 < depth and no jump this cycle. Register mem_req=1 and mem_addr=pc.
  - REQ, mem_ack=1, no jump: push {rdata, pc} into the FIFO and set pc=pc+1 (mod 2^pc_w, wraps 2^pc_w-1 -> 0). If space remains after the push, stay in REQ and issue back-to-back at the new pc; otherwise go to IDLE with mem_req=0.
  - REQ, jump_valid=1, mem_ack=0: go to DRAIN. Keep mem_req=1 and keep mem_addr at its old value until ack (a request is never withdrawn). Set pc=jump_addr.
  - REQ, jump_valid=1 and mem_ack=1 in the same cycle: discard the data, set pc=jump_addr, go to IDLE. The next request is issued the following cycle.
  - DRAIN, mem_ack=1: discard the data, go to IDLE. A further jump while in DRAIN only updates pc.
- Only one outstanding request at any time. A request is issued only when FIFO count < depth, so the FIFO never overflows.
- Latency: mem_ack in cycle N -> out_valid=1 in cycle N+1 (registered FIFO write). First mem_req appears 1 cycle after reset release.
- Output handshake:
  - The FIFO head is popped when out_valid && out_ready.
  - Head data stays stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle keep the count unchanged; a full FIFO accepts a push only alongside a pop.
- Jump wins over everything in its cycle:
  - FIFO cleared; out_valid=0 the next cycle.
  - A pop in the same cycle is ignored; the consumer must not treat it as consumed.
  - In the halt state, halted clears.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - A fetched word whose opcode equals halt_op is pushed normally.
  - The FSM then enters HALTED: mem_req=0 and halted=1 from the cycle after the ack.
  - Remaining FIFO entries still drain.
  - Only jump_valid leaves HALTED (to IDLE with pc=jump_addr, halted=0).
- Undefined: halt_op is an ordinary opcode, HALTED does not exist, halted is tied 0.

Test Plan:
- Reset, memory acks 1 cycle after req, out_ready=1, mem[0..3]=0x01000102,0x02000100,0x03112233,0x04FFFFFF -> out_pc 0,1,2,3 in order. Word 0 yields out_op=1, out_a1=0x00, out_a2=0x01, out_a3=0x02. mem_addr increments by 1.
- out_ready=0 throughout -> exactly depth=2 words fetched, mem_req falls to 0, head out_pc=0 held stable. Raising out_ready resumes fetch at addr 2.
- jump_valid (addr 0x40) while a request to addr 5 is pending and ack is delayed 3 cycles -> mem_addr stays 5 until ack, the addr-5 data never appears on out, the next request is to 0x40, FIFO is empty during the drain.
- jump_valid coincident with mem_ack and with out_valid&&out_ready -> FIFO cleared, acked data dropped, next request at jump_addr in the following cycle.
- pc_w=8, jump to 0xFE -> fetches 0xFE, 0xFF, 0x00. Assert reset_n low mid-REQ -> all outputs return to reset values asynchronously.
- FETCH_HALT_EN, mem[2] op=0 -> instructions 0,1,2 delivered, halted=1, no further mem_req. Jump to 4 -> fetch resumes at 4 and halted=0.
